gpu_line_raster: RTL and testbench

// - Parametrised Bresenham line rasteriser for the GPU draw path; replaces the fixed 320x240/24-bit line logic.
// - Takes two endpoints, a colour and a target frame buffer from the GPU command decoder.
// - Emits one framebuffer pixel write per step over a valid/ready stream to the AHB master write port.
// - Screen size, pixel width, buffer count and address layout are all set by parameters.

---
 rtl/gpu_line_raster_if.sv | 11 +
 rtl/gpu_line_raster.sv | 151 +++++++++++++++
 tb/tb_gpu_line_raster.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/gpu_line_raster_if.sv
// Pixel write stream from the line rasteriser to the AHB master write port.
// master = rasteriser side, slave = memory write side.
interface gpu_line_raster_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] pix_addr;
  logic [31:0] pix_data;

  modport master (output pix_valid, pix_addr, pix_data, input pix_ready);
  modport slave  (input pix_valid, pix_addr, pix_data, output pix_ready);
endinterface

// File: rtl/gpu_line_raster.sv
// Parametrised Bresenham line rasteriser: one framebuffer pixel write per step.
// Optional macro GPU_RASTER_CLIP_EN skips steps outside SCREEN_W x SCREEN_H.
module gpu_line_raster #(
  parameter int          X_BITS        = 9,
  parameter int          Y_BITS        = 8,
  parameter int          SCREEN_W      = 320,
  parameter int          SCREEN_H      = 240,
  parameter int          PIX_BITS      = 24,
  parameter int          NUM_BUFFERS   = 2,
  parameter int          BYTES_PER_PIX = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  localparam int         BUF_BITS      = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [X_BITS-1:0]   x0,
  input  logic [X_BITS-1:0]   x1,
  input  logic [Y_BITS-1:0]   y0,
  input  logic [Y_BITS-1:0]   y1,
  input  logic [PIX_BITS-1:0] color,
  input  logic [BUF_BITS-1:0] buf_sel,
  output logic                busy,
  output logic                done,
  gpu_line_raster_if.master   pix
);

  // Two spare bits: one for sign, one so that 2*err never overflows.
  localparam int CW = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 2;
  typedef logic signed [CW-1:0] coord_t;

  typedef struct packed {
    coord_t              x1;
    coord_t              y1;
    logic [BUF_BITS-1:0] buf_sel;
  } cmd_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_PLOT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  cmd_t        cmd;
  coord_t      cx, cy, dx, dy, err;
  logic        sx_neg, sy_neg;
  logic [31:0] addr_q, data_q;

  coord_t e2, nx, ny, nerr, ddx, ddy, adx, ady;
  logic   vis, last, adv;

  function automatic logic [31:0] addr_of(input coord_t x, input coord_t y,
                                          input logic [BUF_BITS-1:0] b);
    logic [31:0] row;
    row = 32'(b) * 32'(SCREEN_H) + 32'(y);
    return BASE_ADDR + (row * 32'(SCREEN_W) + 32'(x)) * 32'(BYTES_PER_PIX);
  endfunction

  always_comb begin
    ddx = cmd.x1 - cx;
    ddy = cmd.y1 - cy;
    adx = (ddx < 0) ? -ddx : ddx;
    ady = (ddy < 0) ? -ddy : ddy;
  end

  always_comb begin
    e2   = err <<< 1;
    nx   = cx;
    ny   = cy;
    nerr = err;
    if (e2 >= dy) begin
      nerr = nerr + dy;
      nx   = sx_neg ? cx - coord_t'(1) : cx + coord_t'(1);
    end
    if (e2 <= dx) begin
      nerr = nerr + dx;
      ny   = sy_neg ? cy - coord_t'(1) : cy + coord_t'(1);
    end
  end

`ifdef GPU_RASTER_CLIP_EN
  assign vis = (int'(cx) < SCREEN_W) && (int'(cy) < SCREEN_H);
`else
  assign vis = 1'b1;
`endif

  assign last = (cx == cmd.x1) && (cy == cmd.y1);
  // A clipped step advances unconditionally; a visible one waits for ready.
  assign adv  = (state == S_PLOT) && (!vis || pix.pix_ready);

  assign busy          = (state == S_SETUP) || (state == S_PLOT);
  assign done          = (state == S_DONE);
  assign pix.pix_valid = (state == S_PLOT) && vis;
  assign pix.pix_addr  = addr_q;
  assign pix.pix_data  = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cmd    <= '0;
      cx     <= '0;
      cy     <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state       <= S_SETUP;
          cmd.x1      <= coord_t'(x1);
          cmd.y1      <= coord_t'(y1);
          cmd.buf_sel <= buf_sel;
          cx          <= coord_t'(x0);
          cy          <= coord_t'(y0);
          data_q      <= 32'(color);
        end
        S_SETUP: if (abort) begin
          state <= S_IDLE;
        end else begin
          dx     <= adx;
          dy     <= -ady;
          sx_neg <= ddx < 0;
          sy_neg <= ddy < 0;
          err    <= adx - ady;
          addr_q <= addr_of(cx, cy, cmd.buf_sel);
          state  <= S_PLOT;
        end
        S_PLOT: if (abort) begin
          state <= S_IDLE;
        end else if (adv) begin
          if (last) begin
            state <= S_DONE;
          end else begin
            cx     <= nx;
            cy     <= ny;
            err    <= nerr;
            addr_q <= addr_of(nx, ny, cmd.buf_sel);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_line_raster.sv
// Self-checking bench for gpu_line_raster: directed cases plus random lines
// against an integer reference walk of the line.
module tb_gpu_line_raster;

`ifdef GPU_RASTER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [8:0]  x0, x1;
  logic [7:0]  y0, y1;
  logic [23:0] color;
  logic [0:0]  buf_sel;
  logic        busy, done;

  gpu_line_raster_if pif();

  gpu_line_raster dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .color(color), .buf_sel(buf_sel),
    .busy(busy), .done(done), .pix(pif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int n_pts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: visit every point of the line in order, keep the ones that get written.
  task automatic model(input int ax0, input int ay0, input int ax1, input int ay1, input int b);
    int x, y, dx, dy, sx, sy, err, e2;
    exp_q.delete();
    n_pts = 0;
    x = ax0; y = ay0;
    dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy = (ay1 > ay0) ? ay0 - ay1 : ay1 - ay0;
    sx = (ax0 < ax1) ? 1 : -1;
    sy = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    for (int guard = 0; guard < 2000; guard++) begin
      n_pts++;
      if (!CLIP || (x < 320 && y < 240))
        exp_q.push_back(((b * 240 + y) * 320 + x) * 4);
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready held high, 1: random ready. stall_idx: pixel held off 5 cycles.
  // abort_idx: abort while that pixel is presented with ready low.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input logic [23:0] c, input int b, input int mode,
                          input int stall_idx, input int abort_idx);
    int acc = 0, cyc = 0, stall_cnt = 0, span;
    bit prev_hold = 1'b0;
    logic [31:0] prev_addr;
    model(ax0, ay0, ax1, ay1, b);
    span = ((ax1 > ax0) ? ax1 - ax0 : ax0 - ax1);
    if (((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1) > span)
      span = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
    chk("walk_len", 32'(n_pts), 32'(span + 1));

    x0 = 9'(ax0); y0 = 8'(ay0); x1 = 9'(ax1); y1 = 8'(ay1);
    color = c; buf_sel = 1'(b); start = 1'b1;
    tick();
    start = 1'b0;
    x0 = 9'($urandom); y0 = 8'($urandom); x1 = 9'($urandom); y1 = 8'($urandom);
    color = 24'($urandom); buf_sel = 1'($urandom);
    chk("setup_busy", 32'(busy), 32'd1);
    chk("setup_valid", 32'(pif.pix_valid), 32'd0);
    tick();

    while (cyc < 4000) begin
      if (abort_idx >= 0 && acc == abort_idx && pif.pix_valid) begin
        pif.pix_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(pif.pix_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("abort_no_done", 32'(done), 32'd0);
        end
        return;
      end
      if (pif.pix_valid && acc == stall_idx && stall_cnt < 5) begin
        pif.pix_ready = 1'b0;
        stall_cnt++;
      end else begin
        pif.pix_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      chk("plot_busy", 32'(busy), 32'd1);
      if (prev_hold) begin
        chk("hold_valid", 32'(pif.pix_valid), 32'd1);
        chk("hold_addr", pif.pix_addr, prev_addr);
        chk("hold_data", pif.pix_data, 32'(c));
      end
      if (pif.pix_valid) begin
        if (acc < exp_q.size()) chk("pix_addr", pif.pix_addr, 32'(exp_q[acc]));
        else                    chk("pix_overrun", 32'(acc), 32'(exp_q.size() - 1));
        chk("pix_data", pif.pix_data, 32'(c));
        if (pif.pix_ready) acc++;
      end
      prev_hold = pif.pix_valid && !pif.pix_ready;
      prev_addr = pif.pix_addr;
      tick();
      cyc++;
      if (done) break;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("pix_count", 32'(acc), 32'(exp_q.size()));
    if (mode == 0 && stall_idx < 0 && n_pts == exp_q.size())
      chk("throughput", 32'(cyc), 32'(exp_q.size()));
    tick();
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pif.pix_ready = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0; buf_sel = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(pif.pix_valid), 32'd0);
    chk("rst_addr", pif.pix_addr, 32'd0);
    chk("rst_data", pif.pix_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_line(0, 239, 2, 239, 24'hFF0000, 0, 0, -1, -1);
    run_line(3, 3, 0, 0, 24'h123456, 0, 0, -1, -1);
    run_line(0, 0, 0, 0, 24'h00AA55, 1, 0, -1, -1);
    run_line(0, 0, 5, 2, 24'h0F0F0F, 0, 0, 1, -1);
    run_line(0, 0, 9, 0, 24'h777777, 0, 0, -1, 2);
    run_line(318, 0, 322, 0, 24'hABCDEF, 0, 0, -1, -1);
    run_line(10, 200, 2, 5, 24'h010203, 1, 1, -1, -1);

    for (int i = 0; i < 24; i++)
      run_line($urandom_range(0, 330), $urandom_range(0, 250),
               $urandom_range(0, 330), $urandom_range(0, 250),
               24'($urandom), $urandom_range(0, 1), 1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
